// File: rtl/scm_fifo_pkg.sv
// scm_fifo_pkg: shared sizing helpers and status bundle for scm_stream_fifo.
//   cap_f(addr_width) : total FIFO capacity (storage depth + 2-entry output buffer)
//   cw_f(addr_width)  : width of a counter able to hold 0..capacity
//   fifo_status_t     : {empty, full, count} bundle for users that pass status around
package scm_fifo_pkg;

  localparam int unsigned STATUS_CW = 16;

  function automatic int unsigned cap_f(input int unsigned addr_width);
    return (32'd1 << addr_width) + 32'd2;
  endfunction

  function automatic int unsigned cw_f(input int unsigned addr_width);
    return $clog2(cap_f(addr_width) + 32'd1);
  endfunction

  typedef struct packed {
    logic                 empty;
    logic                 full;
    logic [STATUS_CW-1:0] count;
  } fifo_status_t;

endpackage

// File: rtl/register_file_1r_1w_raw.sv
// register_file_1r_1w_raw: 1-read/1-write storage macro with a registered read port.
//   clk                   : clock
//   WriteEnable/Addr/Data : synchronous write port
//   ReadEnable/ReadAddr   : read request; ReadData updates on the following edge
//   ReadData              : registered read data, holds when ReadEnable is low
// Contents are not reset. Write-to-read forwarding on the same address is undefined.
module register_file_1r_1w_raw #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BLOCK_RAM  = 1
) (
  input  logic                  clk,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if (BLOCK_RAM != 0) begin : g_bram
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (WriteEnable) mem_q[WriteAddr] <= WriteData;
      if (ReadEnable)  ReadData <= mem_q[ReadAddr];
    end
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (WriteEnable) mem_q[WriteAddr] <= WriteData;
      if (ReadEnable)  ReadData <= mem_q[ReadAddr];
    end
  end

endmodule

// File: rtl/scm_fifo_outbuf.sv
// scm_fifo_outbuf: 2-entry in-order output buffer hiding the storage read latency.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous flush (wins over capture/pop)
//   capture_i     : load data_i behind the current contents
//   data_i        : read data returning from storage
//   pop_i         : consumer took the head entry
//   valid_o/data_o: head entry
//   cnt_o         : entries held (0..2)
module scm_fifo_outbuf #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      unique case ({capture_i, pop_i})
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) head_d = data_i;
          else               tail_d = data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          // Shift and refill in one step; count is unchanged.
          if (cnt_q == 2'd2) begin
            head_d = tail_q;
            tail_d = data_i;
          end else begin
            head_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q;
  assign cnt_o   = cnt_q;

  // The issue rule upstream guarantees a returning word always has a free slot.
  capture_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(capture_i && !pop_i && (cnt_q == 2'd2)));

endmodule

// File: rtl/scm_stream_fifo.sv
// scm_stream_fifo: valid/ready first-word-fall-through FIFO on a 1r1w storage macro.
//   clk, rst_n            : clock, async active-low reset
//   clear                 : synchronous flush, same effect as reset
//   in_valid/in_data      : producer side; in_ready depends on registers only
//   out_valid/out_data    : consumer side, driven from output buffer registers
//   out_ready             : consumer accepts head
//   count/empty/full      : occupancy = storage + in-flight read + output buffer
module scm_stream_fifo
  import scm_fifo_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 5,
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned BLOCK_RAM  = 1,
  localparam int unsigned NS         = 1 << ADDR_WIDTH,
  localparam int unsigned CAP        = cap_f(ADDR_WIDTH),
  localparam int unsigned CW         = cw_f(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH+1)'(NS);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            out_cnt, occ;
  logic                  push, pop, issue, capture;
  logic [DATA_WIDTH-1:0] rd_data;

  assign in_ready = (mem_cnt_q != MEM_FULL);
  assign push     = in_valid & in_ready & ~clear;
  assign pop      = out_valid & out_ready & ~clear;

  // Words already promised to the output buffer; a new read may only issue if
  // its return will find a free slot, counting a pop happening this cycle.
  assign occ   = out_cnt + {1'b0, rd_inflight_q};
  assign issue = ~clear & (mem_cnt_q != '0) &
                 ((occ < 2'd2) | ((occ == 2'd2) & pop));
  // A return belonging to a flushed read is discarded.
  assign capture = rd_inflight_q & ~clear;

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    mem_cnt_d     = mem_cnt_q;
    rd_inflight_d = issue;
    if (clear) begin
      wptr_d        = '0;
      rptr_d        = '0;
      mem_cnt_d     = '0;
      rd_inflight_d = 1'b0;
    end else begin
      if (push)  wptr_d = wptr_q + 1'b1;
      if (issue) rptr_d = rptr_q + 1'b1;
      if (push && !issue)      mem_cnt_d = mem_cnt_q + 1'b1;
      else if (issue && !push) mem_cnt_d = mem_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  register_file_1r_1w_raw #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_RAM  (BLOCK_RAM)
  ) u_storage (
    .clk         (clk),
    .ReadEnable  (issue),
    .ReadAddr    (rptr_q),
    .ReadData    (rd_data),
    .WriteEnable (push),
    .WriteAddr   (wptr_q),
    .WriteData   (in_data)
  );

  scm_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (clear),
    .capture_i (capture),
    .data_i    (rd_data),
    .pop_i     (pop),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .cnt_o     (out_cnt)
  );

  assign count = CW'(mem_cnt_q) + CW'(rd_inflight_q) + CW'(out_cnt);
  assign empty = (count == '0);
  assign full  = (count == CW'(CAP));

endmodule

// File: doc/scm_stream_fifo.md
Name: scm_stream_fifo

Overview:
- Valid/ready first-word-fall-through FIFO built around the team's 1-read/1-write register-file macro `register_file_1r_1w_raw`, which it uses as bulk storage.
- Owns the write/read pointers and the occupancy count.
- Hides the macro's 1-cycle registered read latency behind a 2-entry output prefetch buffer.
- Used as a stream buffer between SoC/accelerator pipeline stages on FPGA targets.

Parameters:
- ADDR_WIDTH, 5, storage address width; storage depth NS = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, payload width.
- BLOCK_RAM, 1, passed to the storage macro. 1 = block RAM; 0 = distributed registers.
- Derived: CAP = NS + 2 (total capacity); CW = $clog2(CAP+1) (count width).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush
- in_valid  in  1  producer has data
- in_data  in  DATA_WIDTH  producer payload
- in_ready  out  1  FIFO accepts data
- out_valid  out  1  head entry valid
- out_data  out  DATA_WIDTH  head payload
- out_ready  in  1  consumer accepts head
- count  out  CW  total entries held
- empty  out  1  count == 0
- full  out  1  count == CAP

Behaviour:
- Reset (rst_n=0, async): pointers 0, mem_cnt 0, rd_inflight 0, output buffer empty. Resulting outputs: out_valid 0, out_data 0, count 0, empty 1, full 0, in_ready 1.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (mem_cnt != NS); it is a function of registers only and has no combinational path from out_ready.
  - out_valid/out_data come straight from buffer head registers, with no combinational path from in_*.
- Write side: on push, drive storage WriteEnable=1, WriteAddr=wptr, WriteData=in_data. wptr increments mod NS (natural wrap).
- mem_cnt counts entries written to storage and not yet read-issued.
  - +1 on push, -1 on read issue, simultaneous = no change.
- Read issue (cycle t):
  - Condition: mem_cnt != 0 and (out_cnt + rd_inflight < 2, or out_cnt + rd_inflight == 2 with pop in t).
  - Drive ReadEnable=1, ReadAddr=rptr; rptr increments mod NS; set rd_inflight.
  - ReadData is captured into the output buffer at the end of t+1. rd_inflight clears then, unless a new read issues.
- Same-address hazard: a word is only read once it is counted in mem_cnt, i.e. at least one cycle after its write. Never rely on storage write-to-read forwarding; behaviour must be identical for BLOCK_RAM=0/1.
- Output buffer: 2 entries, in-order.
  - Capture and pop in the same cycle are allowed.
  - Head shifts on pop.
  - Capture into a full buffer must be impossible by the issue rule; assert this in simulation.
- Latency: push in cycle 0 to an empty FIFO gives out_valid in cycle 3.
  - Steady state: 1 word/cycle throughput with out_ready held high.
- count = mem_cnt + rd_inflight + out_cnt, registered-consistent. full/empty are derived from count.
- Push when in_ready=0 is ignored; no state change.
- clear: same-cycle effect equals reset. Push/pop in that cycle are discarded. An in-flight read's return is dropped (it is not captured in the following cycle).
- Reset mid-operation: all contents lost; no output glitch beyond the async clear.
- Storage contents are never reset-dependent for correctness.

Decomposition:
- Package `scm_fifo_pkg`:
  - function `cap_f(addr_width)` returning NS+2.
  - count-width helper.
  - typedef `fifo_status_t` {empty, full, count} for users that bundle status.
- Sub-module `scm_fifo_outbuf`: 2-entry in-order output buffer with capture/pop and out_cnt.
- Top-level holds pointers, mem_cnt, issue logic and the storage macro instance.

Test Plan:
- Fill/drain: ADDR_WIDTH=2 (CAP=6), out_ready=0, push 0x1..0x8. Expect in_ready to drop after 6 accepted; full=1, count=6. Then out_ready=1: out_data 0x1..0x6 in order, empty=1.
- Latency: push 0xA5 at cycle 0 into an empty FIFO → out_valid=1, out_data=0xA5 at cycle 3, count=1 from cycle 1.
- Streaming: in_valid=out_ready=1 for 100 cycles with an incrementing pattern → zero bubbles after the initial fill, no loss or reorder, wptr/rptr wrap several times. Run with BLOCK_RAM=0 and 1.
- Random backpressure: random in_valid/out_ready (50%) for 10k cycles against a scoreboard → exact ordering; count matches the model every cycle; output-buffer-overflow assertion never fires.
- clear mid-read: 4 entries held, read in flight, assert clear for 1 cycle → next cycle count=0, out_valid=0, empty=1. Subsequent push 0x77 emerges alone at +3 cycles.
- Async reset during streaming: rst_n low mid-transfer → out_valid=0, count=0 immediately. After release, in_ready=1 and new data flows correctly.
